// File: rtl/a_writeback.sv
// a_writeback: A-register file with a single arbitrated write port.
// Result-bus writes have top priority. A memory load that collides with a
// result write is parked in a one-entry hold register and committed at the
// next cycle with no result write. The block also provides three
// combinational read ports and A0 status flags.
// Ports:
//   clk, rst                          clock, async active-high reset
//   i_a_result_en/_src/_dest          result-bus write command
//   i_src_data                        16 functional-unit results, WIDTH each
//   i_mem_we/_dest/_data, o_mem_stall memory-load write port and back-pressure
//   i_rd_i/j/k -> o_ai/aj/ak          read ports (no bypass)
//   o_a0, o_a0_zero, o_a0_neg         A0 value and status
//   o_a_wr_mask                       one-hot of register written at last edge
//   o_src_err, o_ovf_err, o_drop_err  sticky error flags
module a_writeback #(
  parameter int unsigned WIDTH     = 24,
  parameter logic [15:0] SRC_VALID = 16'h7FFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_a_result_en,
  input  logic [3:0]            i_a_result_src,
  input  logic [2:0]            i_a_result_dest,
  input  logic [16*WIDTH-1:0]   i_src_data,
  input  logic                  i_mem_we,
  input  logic [2:0]            i_mem_dest,
  input  logic [WIDTH-1:0]      i_mem_data,
  output logic                  o_mem_stall,
  input  logic [2:0]            i_rd_i,
  input  logic [2:0]            i_rd_j,
  input  logic [2:0]            i_rd_k,
  output logic [WIDTH-1:0]      o_ai,
  output logic [WIDTH-1:0]      o_aj,
  output logic [WIDTH-1:0]      o_ak,
  output logic [WIDTH-1:0]      o_a0,
  output logic                  o_a0_zero,
  output logic                  o_a0_neg,
  output logic [7:0]            o_a_wr_mask,
  output logic                  o_src_err,
  output logic                  o_ovf_err,
  output logic                  o_drop_err
);

  localparam int unsigned NREG = 8;
  localparam int unsigned NSRC = 16;

  logic [WIDTH-1:0] a_q [NREG];
  logic [WIDTH-1:0] src_arr [NSRC];

  logic             hold_vld, hold_vld_d;
  logic [2:0]       hold_dest, hold_dest_d;
  logic [WIDTH-1:0] hold_data, hold_data_d;
  logic             src_err_d, ovf_err_d, drop_err_d;

  logic             wr_en;
  logic [2:0]       wr_dest;
  logic [WIDTH-1:0] wr_data;

  // Unpack the functional-unit result bus into an indexable array.
  always_comb begin
    for (int n = 0; n < NSRC; n++) begin
      src_arr[n] = i_src_data[n*WIDTH +: WIDTH];
    end
  end

  // Write-port arbitration: result bus, then hold drain, then new load.
  always_comb begin
    wr_en       = 1'b0;
    wr_dest     = 3'd0;
    wr_data     = '0;
    hold_vld_d  = hold_vld;
    hold_dest_d = hold_dest;
    hold_data_d = hold_data;
    src_err_d   = o_src_err;
    ovf_err_d   = o_ovf_err;
    drop_err_d  = o_drop_err;

    if (i_a_result_en) begin
      if (SRC_VALID[i_a_result_src]) begin
        wr_en   = 1'b1;
        wr_dest = i_a_result_dest;
        wr_data = src_arr[i_a_result_src];
        // A newer result to the held destination makes the held load stale.
        if (hold_vld && (hold_dest == i_a_result_dest)) begin
          hold_vld_d = 1'b0;
          drop_err_d = 1'b1;
        end
      end else begin
        src_err_d = 1'b1;
      end
      if (i_mem_we && !hold_vld) begin
        hold_vld_d  = 1'b1;
        hold_dest_d = i_mem_dest;
        hold_data_d = i_mem_data;
      end
    end else if (hold_vld) begin
      wr_en      = 1'b1;
      wr_dest    = hold_dest;
      wr_data    = hold_data;
      hold_vld_d = 1'b0;
    end else if (i_mem_we) begin
      wr_en   = 1'b1;
      wr_dest = i_mem_dest;
      wr_data = i_mem_data;
    end

    // Loads presented while the hold is occupied are lost.
    if (i_mem_we && hold_vld) begin
      ovf_err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        a_q[r] <= '0;
      end
      hold_vld    <= 1'b0;
      hold_dest   <= 3'd0;
      hold_data   <= '0;
      o_a_wr_mask <= 8'd0;
      o_src_err   <= 1'b0;
      o_ovf_err   <= 1'b0;
      o_drop_err  <= 1'b0;
    end else begin
      if (wr_en) begin
        a_q[wr_dest] <= wr_data;
      end
      hold_vld    <= hold_vld_d;
      hold_dest   <= hold_dest_d;
      hold_data   <= hold_data_d;
      o_a_wr_mask <= wr_en ? (8'(1) << wr_dest) : 8'd0;
      o_src_err   <= src_err_d;
      o_ovf_err   <= ovf_err_d;
      o_drop_err  <= drop_err_d;
    end
  end

  assign o_mem_stall = hold_vld;
  assign o_ai        = a_q[i_rd_i];
  assign o_aj        = a_q[i_rd_j];
  assign o_ak        = a_q[i_rd_k];
  assign o_a0        = a_q[0];
  assign o_a0_zero   = (a_q[0] == '0);
  assign o_a0_neg    = a_q[0][WIDTH-1];

endmodule

// File: tb/tb_a_writeback.sv
// Self-checking bench for a_writeback: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model of the register file.
module tb_a_writeback;

  localparam int unsigned WIDTH = 24;
  localparam logic [15:0] SRC_VALID = 16'h7FFF;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_a_result_en;
  logic [3:0]          i_a_result_src;
  logic [2:0]          i_a_result_dest;
  logic [16*WIDTH-1:0] i_src_data;
  logic                i_mem_we;
  logic [2:0]          i_mem_dest;
  logic [WIDTH-1:0]    i_mem_data;
  logic                o_mem_stall;
  logic [2:0]          i_rd_i, i_rd_j, i_rd_k;
  logic [WIDTH-1:0]    o_ai, o_aj, o_ak, o_a0;
  logic                o_a0_zero, o_a0_neg;
  logic [7:0]          o_a_wr_mask;
  logic                o_src_err, o_ovf_err, o_drop_err;

  logic [WIDTH-1:0] src_arr [16];

  a_writeback #(.WIDTH(WIDTH), .SRC_VALID(SRC_VALID)) dut (
    .clk(clk), .rst(rst),
    .i_a_result_en(i_a_result_en), .i_a_result_src(i_a_result_src),
    .i_a_result_dest(i_a_result_dest), .i_src_data(i_src_data),
    .i_mem_we(i_mem_we), .i_mem_dest(i_mem_dest), .i_mem_data(i_mem_data),
    .o_mem_stall(o_mem_stall),
    .i_rd_i(i_rd_i), .i_rd_j(i_rd_j), .i_rd_k(i_rd_k),
    .o_ai(o_ai), .o_aj(o_aj), .o_ak(o_ak),
    .o_a0(o_a0), .o_a0_zero(o_a0_zero), .o_a0_neg(o_a0_neg),
    .o_a_wr_mask(o_a_wr_mask),
    .o_src_err(o_src_err), .o_ovf_err(o_ovf_err), .o_drop_err(o_drop_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int n = 0; n < 16; n++) i_src_data[n*WIDTH +: WIDTH] = src_arr[n];
  end

  // Behavioural model: register array plus a pending-load queue (depth <= 1).
  typedef struct { logic [2:0] d; logic [WIDTH-1:0] v; } ent_t;
  logic [WIDTH-1:0] m_a [8];
  ent_t             hq [$];
  logic [7:0]       m_mask;
  logic             m_src, m_ovf, m_drop;

  int  checks = 0;
  int  failures = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_a[r] = '0;
    hq.delete();
    m_mask = 8'd0; m_src = 1'b0; m_ovf = 1'b0; m_drop = 1'b0;
  endtask

  // Apply this cycle's inputs to the model, yielding the post-edge state.
  task automatic model_step();
    bit busy;
    ent_t e;
    busy   = (hq.size() != 0);
    m_mask = 8'd0;
    if (i_a_result_en) begin
      if (SRC_VALID[i_a_result_src]) begin
        m_a[i_a_result_dest] = src_arr[i_a_result_src];
        m_mask = 8'(1) << i_a_result_dest;
        if (busy && hq[0].d == i_a_result_dest) begin
          hq.delete();
          m_drop = 1'b1;
        end
      end else begin
        m_src = 1'b1;
      end
      if (i_mem_we && !busy) begin
        e.d = i_mem_dest; e.v = i_mem_data;
        hq.push_back(e);
      end
    end else if (busy) begin
      e = hq.pop_front();
      m_a[e.d] = e.v;
      m_mask = 8'(1) << e.d;
    end else if (i_mem_we) begin
      m_a[i_mem_dest] = i_mem_data;
      m_mask = 8'(1) << i_mem_dest;
    end
    if (i_mem_we && busy) m_ovf = 1'b1;
  endtask

  // Per-cycle compare against the model, just after each active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en && !rst) begin
      chk("ai", 32'(o_ai), 32'(m_a[i_rd_i]));
      chk("aj", 32'(o_aj), 32'(m_a[i_rd_j]));
      chk("ak", 32'(o_ak), 32'(m_a[i_rd_k]));
      chk("a0", 32'(o_a0), 32'(m_a[0]));
      chk("a0_zero", 32'(o_a0_zero), 32'(m_a[0] == '0));
      chk("a0_neg", 32'(o_a0_neg), 32'(m_a[0][WIDTH-1]));
      chk("mem_stall", 32'(o_mem_stall), 32'(hq.size() != 0));
      chk("wr_mask", 32'(o_a_wr_mask), 32'(m_mask));
      chk("src_err", 32'(o_src_err), 32'(m_src));
      chk("ovf_err", 32'(o_ovf_err), 32'(m_ovf));
      chk("drop_err", 32'(o_drop_err), 32'(m_drop));
    end
  end

  // Drive one cycle of inputs at the falling edge; sval lands in slice src.
  task automatic cyc(input logic en, input logic [3:0] src, input logic [2:0] dest,
                     input logic [WIDTH-1:0] sval, input logic we,
                     input logic [2:0] md, input logic [WIDTH-1:0] mdata);
    @(negedge clk);
    for (int n = 0; n < 16; n++) src_arr[n] = WIDTH'($urandom);
    src_arr[src]    = sval;
    i_a_result_en   = en;
    i_a_result_src  = src;
    i_a_result_dest = dest;
    i_mem_we        = we;
    i_mem_dest      = md;
    i_mem_data      = mdata;
    i_rd_i = 3'($urandom); i_rd_j = 3'($urandom); i_rd_k = 3'($urandom);
    model_step();
    chk_en = 1'b1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 3'd0, '0, 1'b0, 3'd0, '0);
  endtask

  // Move past the edge (and the compare) before literal checks.
  task automatic settle();
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1'b1;
    i_a_result_en = 1'b0; i_a_result_src = 4'd0; i_a_result_dest = 3'd0;
    i_mem_we = 1'b0; i_mem_dest = 3'd0; i_mem_data = '0;
    i_rd_i = 3'd0; i_rd_j = 3'd0; i_rd_k = 3'd0;
    for (int n = 0; n < 16; n++) src_arr[n] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ai", 32'(o_ai), 32'h0);
    chk("rst_a0_zero", 32'(o_a0_zero), 32'h1);
    chk("rst_stall", 32'(o_mem_stall), 32'h0);
    chk("rst_mask", 32'(o_a_wr_mask), 32'h0);
    @(negedge clk) rst = 1'b0;

    // Result write, src 3 -> A5.
    cyc(1'b1, 4'd3, 3'd5, 24'h00ABCD, 1'b0, 3'd0, '0);
    settle(); i_rd_i = 3'd5; #1;
    chk("res_a5", 32'(o_ai), 32'h00ABCD);
    chk("res_mask", 32'(o_a_wr_mask), 32'h20);
    idle(); settle();
    chk("res_mask_clr", 32'(o_a_wr_mask), 32'h0);

    // Collision then drain.
    cyc(1'b1, 4'd0, 3'd4, 24'h000123, 1'b1, 3'd2, 24'h000011);
    settle(); i_rd_i = 3'd4; i_rd_j = 3'd2; #1;
    chk("col_a4", 32'(o_ai), 32'h000123);
    chk("col_a2_old", 32'(o_aj), 32'h0);
    chk("col_stall", 32'(o_mem_stall), 32'h1);
    idle(); settle(); i_rd_j = 3'd2; #1;
    chk("drain_a2", 32'(o_aj), 32'h000011);
    chk("drain_stall", 32'(o_mem_stall), 32'h0);
    chk("drain_mask", 32'(o_a_wr_mask), 32'h04);

    // Drop: hold dest 6, then result writes A6.
    cyc(1'b1, 4'd1, 3'd0, 24'h000005, 1'b1, 3'd6, 24'h000999);
    settle();
    chk("drop_stall_on", 32'(o_mem_stall), 32'h1);
    cyc(1'b1, 4'd2, 3'd6, 24'h000777, 1'b0, 3'd0, '0);
    settle();
    chk("drop_err", 32'(o_drop_err), 32'h1);
    chk("drop_stall_off", 32'(o_mem_stall), 32'h0);
    idle(); settle(); i_rd_i = 3'd6; #1;
    chk("drop_a6", 32'(o_ai), 32'h000777);

    // Illegal source.
    cyc(1'b1, 4'd15, 3'd3, 24'h00BEEF, 1'b0, 3'd0, '0);
    settle(); i_rd_i = 3'd3; #1;
    chk("ill_a3", 32'(o_ai), 32'h0);
    chk("ill_src_err", 32'(o_src_err), 32'h1);
    chk("ill_mask", 32'(o_a_wr_mask), 32'h0);
    idle(); settle();
    chk("ill_sticky", 32'(o_src_err), 32'h1);

    // A0 status.
    cyc(1'b1, 4'd4, 3'd0, 24'h800000, 1'b0, 3'd0, '0);
    settle();
    chk("a0_neg", 32'(o_a0_neg), 32'h1);
    chk("a0_nz", 32'(o_a0_zero), 32'h0);
    cyc(1'b1, 4'd5, 3'd0, 24'h000000, 1'b0, 3'd0, '0);
    settle();
    chk("a0_zero", 32'(o_a0_zero), 32'h1);

    // Overflow: load while held entry pending is ignored.
    cyc(1'b1, 4'd0, 3'd1, 24'h000001, 1'b1, 3'd3, 24'h000033);
    cyc(1'b1, 4'd0, 3'd2, 24'h000002, 1'b1, 3'd4, 24'h000044);
    settle();
    chk("ovf_err", 32'(o_ovf_err), 32'h1);
    idle(); settle(); i_rd_i = 3'd3; i_rd_j = 3'd4; #1;
    chk("ovf_a3", 32'(o_ai), 32'h000033);
    chk("ovf_a4_kept", 32'(o_aj), 32'h000123);

    // Randomized traffic.
    for (int t = 0; t < 600; t++) begin
      logic       en, we;
      logic [3:0] src;
      en  = ($urandom_range(0, 99) < 55);
      src = 4'($urandom);
      // Illegal sources only when nothing is held.
      if (hq.size() != 0 && !SRC_VALID[src]) src = 4'd0;
      we  = (hq.size() == 0) ? ($urandom_range(0, 99) < 45)
                             : ($urandom_range(0, 99) < 8);
      cyc(en, src, 3'($urandom), WIDTH'($urandom), we, 3'($urandom), WIDTH'($urandom));
    end

    // Mid-cycle asynchronous reset with a held entry pending.
    cyc(1'b1, 4'd0, 3'd4, 24'h0000AA, 1'b1, 3'd5, 24'h0000BB);
    settle();
    chk("pre_rst_stall", 32'(o_mem_stall), 32'h1);
    chk_en = 1'b0;
    i_a_result_en = 1'b0; i_mem_we = 1'b0;
    i_rd_i = 3'd4;
    rst = 1'b1;
    #1;
    chk("arst_ai", 32'(o_ai), 32'h0);
    chk("arst_a0_zero", 32'(o_a0_zero), 32'h1);
    chk("arst_stall", 32'(o_mem_stall), 32'h0);
    chk("arst_mask", 32'(o_a_wr_mask), 32'h0);
    chk("arst_errs", 32'({o_src_err, o_ovf_err, o_drop_err}), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int t = 0; t < 40; t++) begin
      cyc(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 14)), 3'($urandom),
          WIDTH'($urandom), (hq.size() == 0) && ($urandom_range(0, 1) == 1),
          3'($urandom), WIDTH'($urandom));
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
